// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
//
// Ports:
//   i_CLK    - clock, rising edge
//   i_RST    - asynchronous active-low reset
//   i_start  - conversion request, sampled only while idle
//   i_bin    - value to convert, sampled with i_start
//   i_signed - treat i_bin as two's complement, sampled with i_start
//   o_busy   - conversion in progress
//   o_valid  - one-cycle pulse, new result on o_bcd/o_neg/o_blank
//   o_bcd    - result digits, digit 0 (units) in bits [3:0]
//   o_neg    - result is negative
//   o_blank  - leading-zero flags, one per digit (digit 0 never blanked)

module bin2bcd_seq #(
    parameter int unsigned N_BIN = 16,
    parameter int unsigned N_DIG = 5
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    input  logic               i_start,
    input  logic [N_BIN-1:0]   i_bin,
    input  logic               i_signed,
    output logic               o_busy,
    output logic               o_valid,
    output logic [4*N_DIG-1:0] o_bcd,
    output logic               o_neg,
    output logic [N_DIG-1:0]   o_blank
);

    localparam int unsigned CW = $clog2(N_BIN + 1);
    localparam logic [N_DIG-1:0] BLANK_RST = {{(N_DIG - 1){1'b1}}, 1'b0};

    // True when N_DIG decimal digits can hold the largest N_BIN-bit value.
    function automatic bit digits_fit();
        longint unsigned pw;
        pw = 1;
        for (int i = 0; i < int'(N_DIG); i++) pw = pw * 10;
        return pw >= (longint'(1) << N_BIN);
    endfunction

    if (!digits_fit()) begin : g_bad_params
        $error("bin2bcd_seq: N_DIG too small for N_BIN");
    end

    // Digit i is blank when it and every higher digit are zero.
    function automatic logic [N_DIG-1:0] blank_of(input logic [4*N_DIG-1:0] d);
        logic upper_zero;
        blank_of   = '0;
        upper_zero = 1'b1;
        for (int i = int'(N_DIG) - 1; i >= 1; i--) begin
            upper_zero  = upper_zero && (d[4*i +: 4] == 4'd0);
            blank_of[i] = upper_zero;
        end
    endfunction

    typedef enum logic {StIdle, StShift} state_t;

    state_t             state_q, state_d;
    logic [N_BIN-1:0]   sr_q, sr_d;
    logic [4*N_DIG-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [4*N_DIG-1:0] bcd_q, bcd_d;
    logic               neg_q, neg_d;
    logic [N_DIG-1:0]   blank_q, blank_d;
    logic               valid_q, valid_d;
    logic [4*N_DIG-1:0] adj;
    logic [4*N_DIG-1:0] shifted;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        blank_d = blank_q;
        valid_d = 1'b0;

        adj = acc_q;
        for (int i = 0; i < int'(N_DIG); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
        shifted = {adj[4*N_DIG-2:0], sr_q[N_BIN-1]};

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    // Most-negative input negates to itself, which reads back as
                    // the correct unsigned magnitude.
                    sr_d    = (i_signed && i_bin[N_BIN-1]) ? -i_bin : i_bin;
                    sign_d  = i_signed && i_bin[N_BIN-1];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                acc_d = shifted;
                sr_d  = sr_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N_BIN - 1)) begin
                    bcd_d   = shifted;
                    neg_d   = sign_q && (shifted != '0);
                    blank_d = blank_of(shifted);
                    valid_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q <= StIdle;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            blank_q <= BLANK_RST;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            blank_q <= blank_d;
            valid_q <= valid_d;
        end
    end

    assign o_busy  = (state_q == StShift);
    assign o_valid = valid_q;
    assign o_bcd   = bcd_q;
    assign o_neg   = neg_q;
    assign o_blank = blank_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] bin;
    logic        sgn;
    logic        busy;
    logic        valid;
    logic [19:0] bcd;
    logic        neg;
    logic [4:0]  blank;

    int n_pass  = 0;
    int n_total = 0;
    logic [19:0] last_bcd = 20'h0;

    bin2bcd_seq #(.N_BIN(16), .N_DIG(5)) dut (
        .i_CLK   (clk),
        .i_RST   (rst_n),
        .i_start (start),
        .i_bin   (bin),
        .i_signed(sgn),
        .o_busy  (busy),
        .o_valid (valid),
        .o_bcd   (bcd),
        .o_neg   (neg),
        .o_blank (blank)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bin;
        bit          sgn;
        logic [19:0] bcd;
        bit          neg;
        logic [4:0]  blk;
    } vec_t;

    vec_t vt[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Decimal reference: plain division, blanking from magnitude thresholds.
    task automatic model(input logic [15:0] b, input bit s, output logic [19:0] ebcd,
                         output bit eneg, output logic [4:0] eblk);
        int unsigned mag, tmp, pw;
        mag  = (s && b[15]) ? 32'd65536 - 32'(b) : 32'(b);
        eneg = s && b[15];
        tmp  = mag;
        for (int i = 0; i < 5; i++) begin
            ebcd[4*i +: 4] = 4'(tmp % 10);
            tmp = tmp / 10;
        end
        eblk[0] = 1'b0;
        pw = 1;
        for (int i = 1; i < 5; i++) begin
            pw = pw * 10;
            eblk[i] = (mag < pw);
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic conv(input logic [15:0] b, input bit s, input logic [19:0] ebcd,
                        input bit eneg, input logic [4:0] eblk, input string nm);
        int lat, nbusy, nvalid;
        bit held;
        logic [19:0] got_bcd;
        logic got_neg;
        logic [4:0] got_blk;
        lat = 0; nbusy = 0; nvalid = 0; held = 1'b1;
        got_bcd = 'x; got_neg = 'x; got_blk = 'x;
        start = 1'b1; bin = b; sgn = s;
        @(posedge clk); @(negedge clk);
        start = 1'b0; bin = 16'($urandom); sgn = 1'($urandom);
        if (busy) nbusy++;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); @(negedge clk);
            if (busy) nbusy++;
            if (valid) begin
                nvalid++;
                if (lat == 0) begin
                    lat = c; got_bcd = bcd; got_neg = neg; got_blk = blank;
                end
            end else if (lat == 0 && bcd !== last_bcd) held = 1'b0;
        end
        check({nm, "_latency"}, 64'(lat), 64'd16);
        check({nm, "_busy_cycles"}, 64'(nbusy), 64'd16);
        check({nm, "_valid_count"}, 64'(nvalid), 64'd1);
        check({nm, "_hold"}, 64'(held), 64'd1);
        check({nm, "_bcd"}, 64'(got_bcd), 64'(ebcd));
        check({nm, "_neg"}, 64'(got_neg), 64'(eneg));
        check({nm, "_blank"}, 64'(got_blk), 64'(eblk));
        last_bcd = ebcd;
    endtask

    initial begin
        logic [19:0] ebcd;
        bit eneg;
        logic [4:0] eblk;
        logic [15:0] rb;
        bit rs;
        int lat, lat2, nv, nv2;
        bit held;
        logic [19:0] got;

        vt[0] = '{16'h0000, 1'b0, 20'h00000, 1'b0, 5'b11110};
        vt[1] = '{16'hFFFF, 1'b0, 20'h65535, 1'b0, 5'b00000};
        vt[2] = '{16'hFFFF, 1'b1, 20'h00001, 1'b1, 5'b11110};
        vt[3] = '{16'h8000, 1'b1, 20'h32768, 1'b1, 5'b00000};
        vt[4] = '{16'h8000, 1'b0, 20'h32768, 1'b0, 5'b00000};
        vt[5] = '{16'h03E8, 1'b0, 20'h01000, 1'b0, 5'b10000};
        vt[6] = '{16'h7FFF, 1'b1, 20'h32767, 1'b0, 5'b00000};
        vt[7] = '{16'hFF9C, 1'b1, 20'h00100, 1'b1, 5'b11000};

        rst_n = 1'b0; start = 1'b0; bin = '0; sgn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_bcd", 64'(bcd), 64'd0);
        check("rst_neg", 64'(neg), 64'd0);
        check("rst_blank", 64'(blank), 64'b11110);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            conv(vt[i].bin, vt[i].sgn, vt[i].bcd, vt[i].neg, vt[i].blk, $sformatf("tbl%0d", i));

        for (int i = 0; i < 40; i++) begin
            rb = 16'($urandom);
            rs = 1'($urandom);
            if (i == 0) rb = 16'h8000;
            model(rb, rs, ebcd, eneg, eblk);
            conv(rb, rs, ebcd, eneg, eblk, $sformatf("rnd%0d", i));
        end

        // Start ignored mid-conversion, then back-to-back start in the valid cycle.
        lat = 0; nv = 0; got = 'x;
        start = 1'b1; bin = 16'd1234; sgn = 1'b0;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); @(negedge clk);
            if (c == 5) begin start = 1'b1; bin = 16'd9999; end
            if (c == 6) start = 1'b0;
            if (valid) begin nv++; lat = c; got = bcd; end
        end
        check("ign_latency", 64'(lat), 64'd16);
        check("ign_valid_count", 64'(nv), 64'd1);
        check("ign_bcd", 64'(got), 64'h01234);
        start = 1'b1; bin = 16'd42;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        check("b2b_accepted", 64'(busy), 64'd1);
        lat2 = 0; nv2 = 0; held = 1'b1; got = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); @(negedge clk);
            if (valid) begin
                nv2++;
                if (lat2 == 0) begin lat2 = c; got = bcd; end
            end else if (lat2 == 0 && bcd !== 20'h01234) held = 1'b0;
        end
        check("b2b_latency", 64'(lat2), 64'd16);
        check("b2b_valid_count", 64'(nv2), 64'd1);
        check("b2b_hold", 64'(held), 64'd1);
        check("b2b_bcd", 64'(got), 64'h00042);

        // Reset mid-conversion.
        start = 1'b1; bin = 16'd500;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (8) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(valid), 64'd0);
        check("abort_bcd", 64'(bcd), 64'd0);
        check("abort_neg", 64'(neg), 64'd0);
        check("abort_blank", 64'(blank), 64'b11110);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); @(negedge clk);
            if (valid || busy) nv++;
        end
        check("abort_no_valid", 64'(nv), 64'd0);
        last_bcd = 20'h0;
        conv(16'd7, 1'b0, 20'h00007, 1'b0, 5'b11110, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock.
- Sits directly upstream of the 7-segment decode chain. Each 4-bit digit of o_bcd drives one hex2seg instance. o_blank and o_neg let the top level substitute blank or dash patterns.
- Converts values wider than the 2-digit range of the existing decimal lookup, e.g. 16-bit controller measurements, for display on the board's segment displays.

Parameters:
- N_BIN, 16, width of the binary input.
- N_DIG, 5, number of BCD output digits. Must satisfy 10^N_DIG > 2^N_BIN - 1; violation is an elaboration-time error.

Ports:
- i_CLK  in  1  system clock, all logic on rising edge.
- i_RST  in  1  asynchronous, active-low reset.
- i_start  in  1  conversion request; sampled only in IDLE.
- i_bin  in  N_BIN  value to convert; sampled with i_start.
- i_signed  in  1  1 = treat i_bin as two's complement; sampled with i_start.
- o_busy  out  1  high while a conversion is in progress.
- o_valid  out  1  one-cycle pulse: new result on o_bcd/o_neg/o_blank.
- o_bcd  out  4*N_DIG  result; digit i in bits [4i+3:4i], digit 0 = units.
- o_neg  out  1  result is negative (sign to be shown as dash).
- o_blank  out  N_DIG  leading-zero flags, one per digit.

Behaviour:
- Reset (i_RST=0, asynchronous): state=IDLE; o_busy=0, o_valid=0, o_bcd=0, o_neg=0, o_blank={1..1,0} (all digits except digit 0 flagged). Internal shift register and counter cleared.
- FSM states: IDLE, SHIFT.
- IDLE, on an edge with i_start=1:
  - Load magnitude into the shift register: |i_bin| if i_signed=1 and i_bin[N_BIN-1]=1, else i_bin.
  - Magnitude is N_BIN-bit unsigned two's-complement negation. Most-negative input (0x8000 at default width) yields magnitude 0x8000, i.e. 32768.
  - Capture the sign, clear the BCD accumulator, set counter=0, go to SHIFT, set o_busy=1.
- SHIFT, one bit per cycle:
  - For every accumulator digit >=5, add 3 (4-bit, no carry out).
  - Then shift {accumulator, shift register} left by 1; the shift register MSB enters digit 0 bit 0. The counter increments.
  - On the N_BIN-th SHIFT edge:
    - Write the final accumulator to o_bcd and the captured sign to o_neg.
    - o_neg is forced to 0 if the magnitude is 0, so no negative zero.
    - Compute o_blank from the final digits.
    - o_valid=1, o_busy=0, state goes to IDLE.
- Latency: start sampled at edge k; o_valid high in the cycle after edge k+N_BIN (16 cycles at default). o_busy is high for exactly N_BIN cycles.
- o_valid is high for exactly one cycle per accepted start and is 0 otherwise.
- o_bcd, o_neg and o_blank hold the last result during a conversion and until the next completion. No intermediate values are exposed.
- i_start while in SHIFT is ignored: no queueing, no restart.
- i_start in the o_valid cycle (state is IDLE) is accepted, giving back-to-back conversions with a throughput of one per N_BIN+1 cycles.
- i_bin and i_signed are don't-care outside the start-sampling edge.
- o_blank[0]=0 always. For i>=1, o_blank[i]=1 iff digit i and all higher digits are 0.
- Reset mid-conversion aborts immediately:
  - Outputs return to reset values and no o_valid is produced.
  - After release the block is in IDLE and accepts i_start on the first edge.

Test Plan:
- Reset, then i_bin=0, i_signed=0, start: o_valid exactly 16 cycles after the start edge; o_bcd=0x00000, o_neg=0, o_blank=5'b11110.
- i_bin=65535, i_signed=0: o_bcd=0x65535, o_blank=5'b00000. o_busy high for 16 cycles; o_valid single-cycle.
- Signed inputs:
  - i_bin=0xFFFF, i_signed=1: o_bcd=0x00001, o_neg=1, o_blank=5'b11110.
  - i_bin=0x8000, i_signed=1: o_bcd=0x32768, o_neg=1.
  - i_bin=0x8000, i_signed=0: o_bcd=0x32768, o_neg=0.
- Start with 1234, pulse i_start with 9999 at cycle 5: a single o_valid, o_bcd=0x01234. Then assert start with 42 in the o_valid cycle: next o_valid 16 cycles later with 0x00042; o_bcd holds 0x01234 until then.
- Start 500, assert i_RST=0 at cycle 8 for 2 cycles: outputs at reset values immediately, no o_valid afterwards. A new start with 7 yields 0x00007 with normal latency.
